// File: rtl/efuse_pkg.sv
// Shared types and constants for the eFuse access arbiter: FSM states,
// controller mode codes and default timing.
package efuse_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_START   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_DONE    = 3'd5
    } efuse_state_t;

    localparam logic [1:0] MODE_IDLE = 2'b00;
    localparam logic [1:0] MODE_PROG = 2'b01;
    localparam logic [1:0] MODE_READ = 2'b10;

    localparam int unsigned DEF_SETUP_CYC = 16;
    localparam int unsigned DEF_START_CYC = 20;
    localparam int unsigned DEF_PROG_WAIT = 12000;
    localparam int unsigned DEF_READ_WAIT = 400;

    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/efuse_req_pending.sv
// Request pending latches and fixed-priority grant (boot read > program >
// slow-control read) for the eFuse access arbiter.
module efuse_req_pending (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_boot_req,
    input  logic        i_rd_req,
    input  logic        i_pg_req,
    input  logic [31:0] i_pg_data,
    input  logic        i_pg_block,
    input  logic        i_grant_en,
    output logic        o_grant_boot,
    output logic        o_grant_pg,
    output logic        o_grant_rd,
    output logic [31:0] o_pg_word
);

    logic        r_pend_boot;
    logic        r_pend_pg;
    logic        r_pend_rd;
    logic [31:0] r_pg_word;
    logic        w_pg_accept;

    assign w_pg_accept = i_pg_req & ~i_pg_block;
    assign o_pg_word   = r_pg_word;

    always_comb begin
        o_grant_boot = 1'b0;
        o_grant_pg   = 1'b0;
        o_grant_rd   = 1'b0;
        if (i_grant_en) begin
            if (r_pend_boot)     o_grant_boot = 1'b1;
            else if (r_pend_pg)  o_grant_pg   = 1'b1;
            else if (r_pend_rd)  o_grant_rd   = 1'b1;
        end
    end

    // A request arriving on the cycle its own bit is granted re-arms the bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_boot <= 1'b0;
            r_pend_pg   <= 1'b0;
            r_pend_rd   <= 1'b0;
            r_pg_word   <= '0;
        end else begin
            r_pend_boot <= (r_pend_boot & ~o_grant_boot) | i_boot_req;
            r_pend_pg   <= (r_pend_pg & ~o_grant_pg) | w_pg_accept;
            r_pend_rd   <= (r_pend_rd & ~o_grant_rd) | i_rd_req;
            if (w_pg_accept) r_pg_word <= i_pg_data;
        end
    end

endmodule

// File: rtl/efuse_access_arbiter.sv
// Arbitrates boot and slow-control eFuse accesses and sequences the eFuse
// controller. Define EFUSE_PROG_LOCK_EN to lock out programming after one pass.
module efuse_access_arbiter #(
    parameter int unsigned SETUP_CYC = efuse_pkg::DEF_SETUP_CYC,
    parameter int unsigned START_CYC = efuse_pkg::DEF_START_CYC,
    parameter int unsigned PROG_WAIT = efuse_pkg::DEF_PROG_WAIT,
    parameter int unsigned READ_WAIT = efuse_pkg::DEF_READ_WAIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        boot_req,
    input  logic        sc_rd_req,
    input  logic        sc_pg_req,
    input  logic [31:0] sc_pg_data,
    output logic [1:0]  ctrl_mode,
    output logic        ctrl_start,
    output logic [31:0] ctrl_prog,
    input  logic [31:0] efuse_q,
    output logic [31:0] q_data,
    output logic        q_valid,
    output logic        busy,
    output logic        done,
    output logic        err
);
    import efuse_pkg::*;

    localparam int unsigned CNT_MAX = max4(SETUP_CYC, START_CYC, PROG_WAIT, READ_WAIT);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    efuse_state_t     r_state;
    efuse_state_t     w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_term;
    logic             w_cnt_hit;
    logic [1:0]       r_mode;
    logic [31:0]      r_prog_word;
    logic [31:0]      r_q_data;
    logic             r_q_valid;
    logic             w_grant_boot;
    logic             w_grant_pg;
    logic             w_grant_rd;
    logic             w_grant_any;
    logic [31:0]      w_pg_word;
    logic             w_pg_block;

    efuse_req_pending u_pending (
        .clk          (clk),
        .rst          (rst),
        .i_boot_req   (boot_req),
        .i_rd_req     (sc_rd_req),
        .i_pg_req     (sc_pg_req),
        .i_pg_data    (sc_pg_data),
        .i_pg_block   (w_pg_block),
        .i_grant_en   (r_state == ST_IDLE),
        .o_grant_boot (w_grant_boot),
        .o_grant_pg   (w_grant_pg),
        .o_grant_rd   (w_grant_rd),
        .o_pg_word    (w_pg_word)
    );

    assign w_grant_any = w_grant_boot | w_grant_pg | w_grant_rd;

    always_comb begin
        w_term = '0;
        case (r_state)
            ST_SETUP: w_term = CNT_W'(SETUP_CYC - 1);
            ST_START: w_term = CNT_W'(START_CYC - 1);
            ST_WAIT:  w_term = (r_mode == MODE_READ) ? CNT_W'(READ_WAIT - 1)
                                                     : CNT_W'(PROG_WAIT - 1);
            default:  w_term = '0;
        endcase
    end

    assign w_cnt_hit = (r_cnt >= w_term);

    always_comb begin
        w_state_next = r_state;
        ctrl_mode    = (r_state == ST_IDLE) ? MODE_IDLE : r_mode;
        ctrl_start   = (r_state == ST_START);
        busy         = (r_state != ST_IDLE);
        done         = (r_state == ST_DONE);
        case (r_state)
            ST_IDLE:    if (w_grant_any) w_state_next = ST_SETUP;
            ST_SETUP:   if (w_cnt_hit)   w_state_next = ST_START;
            ST_START:   if (w_cnt_hit)   w_state_next = ST_WAIT;
            ST_WAIT: begin
                if (w_cnt_hit)
                    w_state_next = (r_mode == MODE_READ) ? ST_CAPTURE : ST_DONE;
            end
            ST_CAPTURE: w_state_next = ST_DONE;
            ST_DONE:    w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    // Counter restarts on every state change and holds once it reaches the
    // terminal count of the current state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_state_next != r_state)
                r_cnt <= '0;
            else if (!w_cnt_hit)
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode      <= MODE_IDLE;
            r_prog_word <= '0;
            r_q_data    <= '0;
            r_q_valid   <= 1'b0;
        end else begin
            if (w_grant_any) begin
                r_mode    <= w_grant_pg ? MODE_PROG : MODE_READ;
                r_q_valid <= 1'b0;
            end
            if (w_grant_pg) r_prog_word <= w_pg_word;
            if (r_state == ST_CAPTURE) begin
                r_q_data  <= efuse_q;
                r_q_valid <= 1'b1;
            end
        end
    end

    assign ctrl_prog = r_prog_word;
    assign q_data    = r_q_data;
    assign q_valid   = r_q_valid;

`ifdef EFUSE_PROG_LOCK_EN
    logic r_lock;
    logic r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lock <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            if (r_state == ST_DONE && r_mode == MODE_PROG) r_lock <= 1'b1;
            r_err <= sc_pg_req & r_lock;
        end
    end

    assign w_pg_block = r_lock;
    assign err        = r_err;
`else
    assign w_pg_block = 1'b0;
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_efuse_access_arbiter.sv
// Self-checking bench for efuse_access_arbiter: elapsed-time access model plus
// directed scenarios. Honours EFUSE_PROG_LOCK_EN if defined.
module tb_efuse_access_arbiter;

    localparam int S = 4;
    localparam int T = 3;
    localparam int R = 10;
    localparam int P = 20;

    logic        clk;
    logic        rst;
    logic        boot_req;
    logic        sc_rd_req;
    logic        sc_pg_req;
    logic [31:0] sc_pg_data;
    logic [1:0]  ctrl_mode;
    logic        ctrl_start;
    logic [31:0] ctrl_prog;
    logic [31:0] efuse_q;
    logic [31:0] q_data;
    logic        q_valid;
    logic        busy;
    logic        done;
    logic        err;

    efuse_access_arbiter #(
        .SETUP_CYC(S),
        .START_CYC(T),
        .PROG_WAIT(P),
        .READ_WAIT(R)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .boot_req   (boot_req),
        .sc_rd_req  (sc_rd_req),
        .sc_pg_req  (sc_pg_req),
        .sc_pg_data (sc_pg_data),
        .ctrl_mode  (ctrl_mode),
        .ctrl_start (ctrl_start),
        .ctrl_prog  (ctrl_prog),
        .efuse_q    (efuse_q),
        .q_data     (q_data),
        .q_valid    (q_valid),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: an access is a fixed-length window measured from its grant.
    bit          m_act  = 1'b0;
    int          m_t    = 0;
    bit          m_prog = 1'b0;
    logic [31:0] m_word = '0;
    logic [31:0] m_q    = '0;
    bit          m_qv   = 1'b0;
    bit          m_err  = 1'b0;
    bit          m_lock = 1'b0;
    bit          p_boot = 1'b0;
    bit          p_rd   = 1'b0;
    bit          p_pg   = 1'b0;
    logic [31:0] p_word = '0;

    function automatic int acc_len(input bit prog);
        return prog ? (S + T + P + 1) : (S + T + R + 2);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_act = 0; m_t = 0; m_prog = 0; m_word = '0; m_q = '0; m_qv = 0;
            m_err = 0; m_lock = 0; p_boot = 0; p_rd = 0; p_pg = 0; p_word = '0;
        end else begin
            bit lk;
            lk = m_lock;
            m_err = 0;
            if (m_act) begin
                if (!m_prog && m_t == S + T + R) begin
                    m_q = efuse_q;
                    m_qv = 1;
                end
                if (m_t == acc_len(m_prog) - 1) begin
                    m_act = 0;
`ifdef EFUSE_PROG_LOCK_EN
                    if (m_prog) m_lock = 1;
`endif
                end else begin
                    m_t++;
                end
            end else if (p_boot || p_pg || p_rd) begin
                m_act = 1; m_t = 0; m_qv = 0;
                if (p_boot) begin
                    m_prog = 0; p_boot = 0;
                end else if (p_pg) begin
                    m_prog = 1; p_pg = 0; m_word = p_word;
                end else begin
                    m_prog = 0; p_rd = 0;
                end
            end
            if (boot_req)  p_boot = 1;
            if (sc_rd_req) p_rd = 1;
            if (sc_pg_req) begin
                if (lk) begin
                    m_err = 1;
                end else begin
                    p_pg = 1;
                    p_word = sc_pg_data;
                end
            end
        end
    end

    int         n_total = 0;
    int         n_bad = 0;
    int         n_start_hi = 0;
    int         n_done = 0;
    int         n_prog_cyc = 0;
    bit         prev_busy = 0;
    logic [1:0] modes[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        logic [1:0] e_mode;
        @(negedge clk);
        e_mode = m_act ? (m_prog ? 2'b01 : 2'b10) : 2'b00;
        chk("ctrl_mode", 32'(ctrl_mode), 32'(e_mode));
        chk("ctrl_start", 32'(ctrl_start), 32'(m_act && m_t >= S && m_t < S + T));
        chk("ctrl_prog", ctrl_prog, m_word);
        chk("q_data", q_data, m_q);
        chk("q_valid", 32'(q_valid), 32'(m_qv));
        chk("busy", 32'(busy), 32'(m_act));
        chk("done", 32'(done), 32'(m_act && m_t == acc_len(m_prog) - 1));
        chk("err", 32'(err), 32'(m_err));
        if (ctrl_start) n_start_hi++;
        if (done) n_done++;
        if (ctrl_mode == 2'b01) n_prog_cyc++;
        if (busy && !prev_busy) modes.push_back(ctrl_mode);
        prev_busy = busy;
    endtask

    task automatic pulse(input bit b, input bit r, input bit p, input logic [31:0] d);
        boot_req = b;
        sc_rd_req = r;
        sc_pg_req = p;
        if (p) sc_pg_data = d;
        tick();
        boot_req = 0;
        sc_rd_req = 0;
        sc_pg_req = 0;
    endtask

    task automatic wait_quiet(input int budget);
        int n;
        n = 0;
        while ((m_act || p_boot || p_rd || p_pg) && n < budget) begin
            tick();
            n++;
        end
        chk("quiet_in_budget", 32'(n < budget), 32'd1);
        tick();
    endtask

    int base_start, base_done, base_prog, base_modes, cnt;

    initial begin
        rst = 1; boot_req = 0; sc_rd_req = 0; sc_pg_req = 0;
        sc_pg_data = '0; efuse_q = '0;
        tick(); tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mode", 32'(ctrl_mode), 32'd0);
        chk("rst_qdata", q_data, 32'd0);
        chk("rst_qvalid", 32'(q_valid), 32'd0);
        chk("rst_prog", ctrl_prog, 32'd0);
        rst = 0;
        tick(); tick();

        // Boot auto-read.
        efuse_q = 32'hA5A5_5A5A;
        base_start = n_start_hi; base_prog = n_prog_cyc; base_done = n_done;
        boot_req = 1;
        cnt = 0;
        do begin
            tick();
            boot_req = 0;
            cnt++;
        end while (!q_valid && cnt < 100);
        chk("boot_qvalid_latency", 32'(cnt), 32'(S + T + R + 3));
        chk("boot_qdata", q_data, 32'hA5A5_5A5A);
        wait_quiet(100);
        chk("boot_start_width", 32'(n_start_hi - base_start), 32'd3);
        chk("boot_no_prog_mode", 32'(n_prog_cyc - base_prog), 32'd0);
        chk("boot_done_once", 32'(n_done - base_done), 32'd1);

        // Slow-control program.
        base_done = n_done;
        pulse(0, 0, 1, 32'h1234_5678);
        sc_pg_data = 32'hDEAD_BEEF;
        tick();
        chk("pg_grant_qvalid", 32'(q_valid), 32'd0);
        cnt = 0;
        while (busy && cnt < 200) begin
            chk("pg_mode_stable", 32'(ctrl_mode), 32'd1);
            chk("pg_word_stable", ctrl_prog, 32'h1234_5678);
            tick();
            cnt++;
        end
        chk("pg_access_len", 32'(cnt), 32'(S + T + P + 1));
        chk("pg_done_once", 32'(n_done - base_done), 32'd1);
        tick();

        // Second program request: locked out or accepted depending on build.
        base_prog = n_prog_cyc;
        pulse(0, 0, 1, 32'h0F0F_0F0F);
`ifdef EFUSE_PROG_LOCK_EN
        chk("lock_err", 32'(err), 32'd1);
        for (int i = 0; i < 40; i++) tick();
        chk("lock_no_prog", 32'(n_prog_cyc - base_prog), 32'd0);
`else
        chk("nolock_err", 32'(err), 32'd0);
        wait_quiet(200);
        chk("nolock_prog_runs", 32'(n_prog_cyc - base_prog), 32'(S + T + P + 1));
`endif

        // Simultaneous requests.
        efuse_q = 32'h0BAD_CAFE;
        base_modes = modes.size(); base_done = n_done;
        pulse(1, 1, 1, 32'hCAFE_0001);
        wait_quiet(400);
`ifdef EFUSE_PROG_LOCK_EN
        chk("sim_count", 32'(modes.size() - base_modes), 32'd2);
        chk("sim_done", 32'(n_done - base_done), 32'd2);
        chk("sim_first", 32'(modes[base_modes]), 32'd2);
        chk("sim_second", 32'(modes[base_modes + 1]), 32'd2);
`else
        chk("sim_count", 32'(modes.size() - base_modes), 32'd3);
        chk("sim_done", 32'(n_done - base_done), 32'd3);
        chk("sim_first", 32'(modes[base_modes]), 32'd2);
        chk("sim_second", 32'(modes[base_modes + 1]), 32'd1);
        chk("sim_third", 32'(modes[base_modes + 2]), 32'd2);
        chk("sim_prog_word", ctrl_prog, 32'hCAFE_0001);
`endif
        chk("sim_qdata", q_data, 32'h0BAD_CAFE);

        // Two slow-control reads while busy collapse into one more read.
        base_modes = modes.size();
        pulse(0, 1, 0, '0);
        tick(); tick();
        pulse(0, 1, 0, '0);
        tick(); tick(); tick();
        pulse(0, 1, 0, '0);
        wait_quiet(200);
        chk("dbl_rd_count", 32'(modes.size() - base_modes), 32'd2);
        chk("dbl_rd_mode", 32'(modes[modes.size() - 1]), 32'd2);

        // Reset during the WAIT phase of a program access.
        rst = 1; tick(); rst = 0; tick();
        pulse(0, 0, 1, 32'h5555_AAAA);
        for (int i = 0; i < S + T + 4; i++) tick();
        chk("pre_rst_mode", 32'(ctrl_mode), 32'd1);
        #3 rst = 1;
        #1;
        chk("async_rst_start", 32'(ctrl_start), 32'd0);
        chk("async_rst_mode", 32'(ctrl_mode), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        tick(); tick();
        rst = 0;
        base_modes = modes.size();
        for (int i = 0; i < 40; i++) tick();
        chk("post_rst_idle", 32'(modes.size() - base_modes), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/efuse_access_arbiter.md
EFUSE_ACCESS_ARBITER -- requirements
Module: efuse_access_arbiter

Interface
REQ-001 Parameter SETUP_CYC, default 16: cycles mode is held before start asserts.
REQ-002 Parameter START_CYC, default 20: width of ctrl_start pulse in cycles.
REQ-003 Parameter PROG_WAIT, default 12000: cycles allowed for a full 32-bit program pass.
REQ-004 Parameter READ_WAIT, default 400: cycles allowed for a read pass before capture.
REQ-005 Ports:
- clk  in  1  40 MHz system clock.
- rst  in  1  asynchronous, active-high reset.
- boot_req  in  1  power-on auto-read request, pulse.
- sc_rd_req  in  1  slow-control read request, pulse.
- sc_pg_req  in  1  slow-control program request, pulse.
- sc_pg_data  in  32  program word, sampled with sc_pg_req.
- ctrl_mode  out  2  to eFuse controller: 2'b00 idle, 2'b01 program, 2'b10 read.
- ctrl_start  out  1  start to eFuse controller.
- ctrl_prog  out  32  program word to eFuse controller.
- efuse_q  in  32  eFuse parallel outputs.
- q_data  out  32  captured eFuse word.
- q_valid  out  1  q_data holds a completed read.
- busy  out  1  access in progress.
- done  out  1  one-cycle pulse at access end.
- err  out  1  one-cycle pulse on a rejected request.

Function
REQ-006 Each request pulse SHALL set its own pending bit. A pulse on an already-pending bit SHALL be absorbed without error.
REQ-007 sc_pg_data SHALL be latched on the cycle sc_pg_req is high. A later sc_pg_req while programming is pending SHALL overwrite the latched word.
REQ-008 In IDLE with any bit pending, grant priority SHALL be fixed: boot read > program > slow-control read. The granted pending bit SHALL clear on the grant cycle.
REQ-009 FSM states:
- IDLE -> SETUP on grant.
- SETUP -> START after SETUP_CYC cycles.
- START -> WAIT after START_CYC cycles.
- WAIT -> CAPTURE when the read counter reaches READ_WAIT; WAIT -> DONE when the program counter reaches PROG_WAIT.
- CAPTURE -> DONE after one cycle.
- DONE -> IDLE after one cycle.
REQ-010 ctrl_mode SHALL hold the granted mode from SETUP through DONE and SHALL be 2'b00 in IDLE.
REQ-011 ctrl_start SHALL be high only in START. ctrl_prog SHALL be driven from the latched word and be stable from SETUP to DONE.
REQ-012 CAPTURE SHALL load efuse_q into q_data and set q_valid. Starting a new read grant SHALL clear q_valid. A program grant SHALL also clear q_valid, because the fuse content changes.
REQ-013 busy SHALL be high in every state except IDLE. done SHALL pulse in DONE.
REQ-014 Requests arriving while busy SHALL only pend and SHALL be served in priority order after DONE, with at least one IDLE cycle between accesses.
REQ-015 Counters SHALL be wide enough for the largest parameter, SHALL saturate at terminal count and SHALL reset to 0 on every state entry.

Reset
REQ-016 On rst high, asynchronously: state IDLE, all pending bits 0, ctrl_mode 2'b00, ctrl_start 0, ctrl_prog 0, q_data 0, q_valid 0, busy 0, done 0, err 0, lock 0.
REQ-017 Reset mid-access SHALL abort immediately and drop ctrl_start and ctrl_mode in the same asynchronous event. No access SHALL resume on release.

Configuration
REQ-018 With EFUSE_PROG_LOCK_EN defined: a lock flag SHALL set on DONE of a program access. Any later sc_pg_req SHALL pulse err and SHALL NOT set the program pending bit. Reads are unaffected. Only rst clears the lock.
REQ-019 Without EFUSE_PROG_LOCK_EN: no lock flag exists, all program requests are accepted, and err SHALL be tied to 0.

Structure
REQ-020 A shared package efuse_pkg SHALL hold the FSM state encoding, the mode constants (MODE_IDLE 2'b00, MODE_PROG 2'b01, MODE_READ 2'b10) and the default timing constants.
REQ-021 A sub-module efuse_req_pending SHALL implement the request latches and the fixed-priority grant.

Verification
REQ-022 rst release, then boot_req pulse with efuse_q=32'hA5A5_5A5A:
- ctrl_mode=01 is never seen.
- ctrl_start is high exactly START_CYC cycles.
- q_data=32'hA5A5_5A5A and q_valid=1 after SETUP_CYC+START_CYC+READ_WAIT+1 cycles.
REQ-023 sc_pg_req with data 32'h1234_5678:
- ctrl_mode=01 and ctrl_prog=32'h1234_5678 are stable through the access.
- done pulses once.
- q_valid clears at grant.
REQ-024 boot_req, sc_pg_req and sc_rd_req in the same cycle: accesses run in the order read, program, read, each followed by its own done pulse.
REQ-025 rst asserted during WAIT of a program access: ctrl_start=0 and ctrl_mode=00 immediately, busy=0, and there is no activity after release.
REQ-026 With EFUSE_PROG_LOCK_EN defined, a second sc_pg_req after one completed program pulses err, and ctrl_mode stays 00.
REQ-027 sc_rd_req pulsed twice during a busy access produces exactly one further read access.
